// File: rtl/stdout_sink_mux.sv
// ---------------------------------------------------------------------------
// stdout_sink_mux
//
// Multi-channel sink for compiled-program standard-output ports. Several
// Ready/Ack producers are arbitrated round-robin. Each accepted word is tagged
// with its channel number and pushed into a first-word-fall-through FIFO that
// a host drains. When the FIFO is full, the sink either applies backpressure
// (DROP_WHEN_FULL = 0) or acks and discards the word (DROP_WHEN_FULL = 1).
//
// Ports
//   clockInput         single clock, rising edge
//   resetInput         asynchronous, active-high reset
//   stdOutReadyInput   per-channel "word available"
//   stdOutDataInput    channel c occupies bits [c*WIDTH +: WIDTH]
//   stdOutAckOutput    registered one-cycle ack, one-hot or zero
//   readDataOutput     head-of-FIFO word (0 when empty)
//   readChannelOutput  head-of-FIFO channel tag (0 when empty)
//   readValidOutput    FIFO not empty
//   readAckInput       pop head; ignored when empty
//   fillOutput         FIFO occupancy
//   wordCountOutput    words written to the FIFO, wraps
//   dropCountOutput    words discarded, saturates at 0xFFFF
// ---------------------------------------------------------------------------
module stdout_sink_mux #(
    parameter int WIDTH          = 32,
    parameter int CHANNELS       = 2,
    parameter int DEPTH          = 16,
    parameter int DROP_WHEN_FULL = 0,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int FW = $clog2(DEPTH + 1)
) (
    input  logic                      clockInput,
    input  logic                      resetInput,
    input  logic [CHANNELS-1:0]       stdOutReadyInput,
    input  logic [CHANNELS*WIDTH-1:0] stdOutDataInput,
    output logic [CHANNELS-1:0]       stdOutAckOutput,
    output logic [WIDTH-1:0]          readDataOutput,
    output logic [CW-1:0]             readChannelOutput,
    output logic                      readValidOutput,
    input  logic                      readAckInput,
    output logic [FW-1:0]             fillOutput,
    output logic [31:0]               wordCountOutput,
    output logic [15:0]               dropCountOutput
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = CW + WIDTH;
    localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_ONE = FW'(1'b1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       last_grant_q, last_grant_d;
    logic [CHANNELS-1:0] ack_q, ack_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [31:0]         word_cnt_q, word_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [EW-1:0]       mem_q [DEPTH];

    logic                grant_vld_s;
    logic [CW-1:0]       grant_s;
    logic [WIDTH-1:0]    grant_data_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic                drop_s;
    logic [EW-1:0]       head_s;

    // Round-robin search: first ready channel starting just after the last grant.
    always_comb begin
        int cand;
        grant_vld_s = 1'b0;
        grant_s     = {CW{1'b0}};
        cand        = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = int'(last_grant_q) + i;
            cand = (cand >= CHANNELS) ? (cand - CHANNELS) : cand;
            if (!grant_vld_s && stdOutReadyInput[cand[CW-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_s     = cand[CW-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        grant_data_s = WIDTH'(stdOutDataInput >> (int'(grant_s) * WIDTH));
    end

    // Event decode; fullness is judged before any same-cycle pop.
    always_comb begin
        full_s = (fill_q == DEPTH_F);
        pop_s  = readAckInput && (fill_q != {FW{1'b0}});
        push_s = (state_q == ST_IDLE) && grant_vld_s && !full_s;
        drop_s = (state_q == ST_IDLE) && grant_vld_s && full_s && (DROP_WHEN_FULL != 0);
    end

    // FSM next state, ack and counters.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ack_d        = {CHANNELS{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (push_s || drop_s) begin
                    state_d      = ST_ACK;
                    last_grant_d = grant_s;
                    ack_d        = CHANNELS'(1'b1) << grant_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (push_s) begin
            word_cnt_d = word_cnt_q + 32'd1;
        end else begin
            word_cnt_d = word_cnt_q;
        end

        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // FIFO pointer and occupancy next state.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s && !pop_s) begin
            fill_d = fill_q + FILL_ONE;
        end else if (!push_s && pop_s) begin
            fill_d = fill_q - FILL_ONE;
        end else begin
            fill_d = fill_q;
        end
    end

    // Control and counter registers.
    always_ff @(posedge clockInput or posedge resetInput) begin
        if (resetInput) begin
            state_q      <= ST_IDLE;
            last_grant_q <= CW'(CHANNELS - 1);
            ack_q        <= {CHANNELS{1'b0}};
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            fill_q       <= {FW{1'b0}};
            word_cnt_q   <= 32'd0;
            drop_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            word_cnt_q   <= word_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // FIFO storage; contents are unreset, the read side masks them when empty.
    always_ff @(posedge clockInput) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {grant_s, grant_data_s};
        end
    end

    // Output drive from registers and storage only.
    always_comb begin
        head_s            = mem_q[rd_ptr_q];
        stdOutAckOutput   = ack_q;
        fillOutput        = fill_q;
        wordCountOutput   = word_cnt_q;
        dropCountOutput   = drop_cnt_q;
        readValidOutput   = (fill_q != {FW{1'b0}});
        if (readValidOutput) begin
            readDataOutput    = head_s[WIDTH-1:0];
            readChannelOutput = head_s[WIDTH +: CW];
        end else begin
            readDataOutput    = {WIDTH{1'b0}};
            readChannelOutput = {CW{1'b0}};
        end
    end

endmodule

// File: tb/tb_stdout_sink_mux.sv
`timescale 1ns/1ps
// Bench: two sink instances (3 channels with backpressure, 2 channels with
// drop-on-full, both DEPTH=4) driven by producers and a reader, compared every
// cycle against a queue-based model, plus literal checkpoints.
module tb_stdout_sink_mux;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    int   mode   = 0;   // 0 quiet, 1 all ready no pop, 2 all ready pop always, 3 random
    bit   chk_en = 1'b0;
    bit   pop_once [2];

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s[inst%0d] @%0t: got 0x%0h expected 0x%0h", name, inst, $time, got, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int CH  = (g == 0) ? 3 : 2;
        localparam int CWL = (CH > 1) ? $clog2(CH) : 1;
        localparam int DEP = 4;

        logic [CH-1:0]    ready;
        logic [CH*32-1:0] data;
        logic [CH-1:0]    ack;
        logic [31:0]      rdata;
        logic [CWL-1:0]   rch;
        logic             rvalid;
        logic             rack;
        logic [2:0]       fill;
        logic [31:0]      wcnt;
        logic [15:0]      dcnt;

        stdout_sink_mux #(.WIDTH(32), .CHANNELS(CH), .DEPTH(DEP), .DROP_WHEN_FULL(g)) dut (
            .clockInput       (clk),
            .resetInput       (rst),
            .stdOutReadyInput (ready),
            .stdOutDataInput  (data),
            .stdOutAckOutput  (ack),
            .readDataOutput   (rdata),
            .readChannelOutput(rch),
            .readValidOutput  (rvalid),
            .readAckInput     (rack),
            .fillOutput       (fill),
            .wordCountOutput  (wcnt),
            .dropCountOutput  (dcnt)
        );

        // Reference model: queue of {tag, data}, last winner, pending-ack flag.
        logic [39:0] mq[$];
        int          m_last;
        bit          m_in_ack;
        int          m_ack_ch;
        logic [31:0] m_wcnt;
        logic [15:0] m_dcnt;

        // Model update on each accepted clock edge, reset asynchronously.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mq.delete();
                m_last   = CH - 1;
                m_in_ack = 1'b0;
                m_ack_ch = 0;
                m_wcnt   = 32'd0;
                m_dcnt   = 16'd0;
            end else begin
                bit do_pop;
                int gsel;
                do_pop = rack && (mq.size() > 0);
                if (m_in_ack) begin
                    m_in_ack = 1'b0;
                end else begin
                    gsel = -1;
                    for (int i = 1; i <= CH; i++)
                        if (gsel < 0 && ready[(m_last + i) % CH]) gsel = (m_last + i) % CH;
                    if (gsel >= 0) begin
                        if (mq.size() < DEP) begin
                            mq.push_back({8'(gsel), data[gsel*32 +: 32]});
                            m_wcnt   = m_wcnt + 32'd1;
                            m_last   = gsel;
                            m_in_ack = 1'b1;
                            m_ack_ch = gsel;
                        end else if (g == 1) begin
                            if (m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
                            m_last   = gsel;
                            m_in_ack = 1'b1;
                            m_ack_ch = gsel;
                        end
                    end
                end
                if (do_pop) void'(mq.pop_front());
            end
        end

        // Per-cycle comparison of every output against the model.
        initial forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                logic [CH-1:0]  eack;
                logic [31:0]    edata;
                logic [CWL-1:0] ech;
                eack  = m_in_ack ? CH'(1 << m_ack_ch) : '0;
                edata = (mq.size() > 0) ? mq[0][31:0] : 32'd0;
                ech   = (mq.size() > 0) ? mq[0][32 +: CWL] : '0;
                check("ack",    g, 64'(ack),    64'(eack));
                check("valid",  g, 64'(rvalid), 64'(mq.size() > 0));
                check("data",   g, 64'(rdata),  64'(edata));
                check("tag",    g, 64'(rch),    64'(ech));
                check("fill",   g, 64'(fill),   64'(mq.size()));
                check("wcount", g, 64'(wcnt),   64'(m_wcnt));
                check("dcount", g, 64'(dcnt),   64'(m_dcnt));
            end
        end

        // Producers and reader, updated away from the active edge.
        initial begin
            ready = '0;
            data  = '0;
            rack  = 1'b0;
            forever begin
                @(negedge clk);
                for (int c = 0; c < CH; c++) begin
                    if (mode == 0) data[c*32 +: 32] = 32'h100 * (c + 1);
                    else if (ack[c]) data[c*32 +: 32] = (mode == 3) ? $urandom : data[c*32 +: 32] + 32'd1;
                end
                case (mode)
                    0:       ready = '0;
                    1, 2:    ready = '1;
                    default: for (int c = 0; c < CH; c++) ready[c] = ($urandom_range(0, 3) != 0);
                endcase
                rack = (mode == 2) || (mode == 3 && $urandom_range(0, 1) == 1) || pop_once[g];
                pop_once[g] = 1'b0;
            end
        end
    end

    task automatic reset_state_checks();
        check("rst_ack0",   0, 64'(inst[0].ack),    64'd0);
        check("rst_ack1",   1, 64'(inst[1].ack),    64'd0);
        check("rst_fill0",  0, 64'(inst[0].fill),   64'd0);
        check("rst_fill1",  1, 64'(inst[1].fill),   64'd0);
        check("rst_valid0", 0, 64'(inst[0].rvalid), 64'd0);
        check("rst_valid1", 1, 64'(inst[1].rvalid), 64'd0);
        check("rst_wcnt0",  0, 64'(inst[0].wcnt),   64'd0);
        check("rst_dcnt1",  1, 64'(inst[1].dcnt),   64'd0);
        check("rst_data0",  0, 64'(inst[0].rdata),  64'd0);
        check("rst_tag0",   0, 64'(inst[0].rch),    64'd0);
    endtask

    // Main sequence.
    initial begin
        bit seen;
        rst  = 1'b1;
        mode = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_state_checks();
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All channels ready, no reads: 7 offers over 14 cycles.
        mode = 1;
        repeat (14) @(posedge clk);
        #1;
        check("bp_fill",   0, 64'(inst[0].fill),  64'd4);
        check("bp_wcnt",   0, 64'(inst[0].wcnt),  64'd4);
        check("bp_ack",    0, 64'(inst[0].ack),   64'd0);
        check("bp_head",   0, 64'(inst[0].rdata), 64'h100);
        check("dr_fill",   1, 64'(inst[1].fill),  64'd4);
        check("dr_wcnt",   1, 64'(inst[1].wcnt),  64'd4);
        check("dr_dcnt",   1, 64'(inst[1].dcnt),  64'd3);
        check("dr_head",   1, 64'(inst[1].rdata), 64'h100);

        // One pop on the backpressured instance frees a slot for channel 1.
        pop_once[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pop_ack",   0, 64'(inst[0].ack),   64'b010);
        check("pop_wcnt",  0, 64'(inst[0].wcnt),  64'd5);
        check("pop_fill",  0, 64'(inst[0].fill),  64'd4);
        check("pop_head",  0, 64'(inst[0].rdata), 64'h200);
        check("pop_tag",   0, 64'(inst[0].rch),   64'd1);

        // Streaming with a pop every cycle, then random traffic.
        mode = 2;
        repeat (100) @(posedge clk);
        #1;
        mode = 3;
        repeat (600) @(posedge clk);
        #1;

        // Reset in the middle of an ack cycle.
        mode = 2;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = (inst[0].ack != '0);
        end
        check("ack_before_reset", 0, 64'(seen), 64'd1);
        #2 rst = 1'b1;
        #1;
        reset_state_checks();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_grant", 0, 64'(inst[0].ack), 64'b001);
        check("post_rst_grant", 1, 64'(inst[1].ack), 64'b01);
        repeat (20) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
